// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
// Request decode (size, support, alignment) lives here so top and lane logic agree.
package lsu_pkg;
    typedef enum logic [2:0] {IDLE, RD, RD1, WR, WR1, RESP} lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

    function automatic lsu_size_e size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic is_supported(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_aligned(input lsu_size_e sz, input logic [1:0] off);
        case (sz)
            SZ_B:    return 1'b1;
            SZ_H:    return !off[0];
            default: return off == 2'b00;
        endcase
    endfunction

    // True when the access spills into the following word.
    function automatic logic crosses_word(input lsu_size_e sz, input logic [1:0] off);
        case (sz)
            SZ_H:    return off == 2'b11;
            SZ_W:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering over the 64-bit window {word1, word0}:
// load extraction/extension and store read-modify-write merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [63:0] window,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_lo,
    output logic [31:0] store_hi
);
    logic [5:0]  shamt;
    logic [31:0] load_word;
    logic [63:0] lane_mask;
    logic [63:0] lane_data;
    logic [63:0] merged;

    assign shamt     = {offset, 3'b000};
    assign load_word = 32'(window >> shamt);

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{load_word[7]}}, load_word[7:0]};
            F3_H:    load_data = {{16{load_word[15]}}, load_word[15:0]};
            F3_BU:   load_data = {24'b0, load_word[7:0]};
            F3_HU:   load_data = {16'b0, load_word[15:0]};
            default: load_data = load_word;
        endcase
    end

    always_comb begin
        case (size_of(funct3))
            SZ_B:    lane_mask = 64'h0000_0000_0000_00FF << shamt;
            SZ_H:    lane_mask = 64'h0000_0000_0000_FFFF << shamt;
            default: lane_mask = 64'h0000_0000_FFFF_FFFF << shamt;
        endcase
    end

    assign lane_data = {32'b0, wdata} << shamt;
    assign merged    = (window & ~lane_mask) | (lane_data & lane_mask);
    assign store_lo  = merged[31:0];
    assign store_hi  = merged[63:32];
endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: sequences word reads/writes for RV32 loads and stores.
// Define LSU_MISALIGN_SPLIT_EN to perform misaligned accesses instead of flagging them.
//
// state | meaning
// IDLE  | ready for a request
// RD    | read first (or only) word
// RD1   | read following word of a split access
// WR    | write first (or only) merged word
// WR1   | write following word of a split access
// RESP  | one-cycle response
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rd
);
    if (DATA_W != 32) begin : g_bad_width
        $error("load_store_unit supports DATA_W=32 only");
    end

    lsu_state_e        state, nxt;
    logic              we_q, err_q, cross_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [DATA_W-1:0] wdata_q, word0_q, word1_q;
    logic [ADDR_W-1:0] adr_q;

    lsu_size_e req_size;
    logic      req_err, req_cross, req_direct_wr;
    logic [31:0] load_data, store_lo, store_hi;

    assign req_size = size_of(req_funct3);
`ifdef LSU_MISALIGN_SPLIT_EN
    assign req_err   = !is_supported(req_we, req_funct3);
    assign req_cross = crosses_word(req_size, req_addr[1:0]);
`else
    assign req_err   = !is_supported(req_we, req_funct3) || !is_aligned(req_size, req_addr[1:0]);
    assign req_cross = 1'b0;
`endif
    // A full-word store in one word needs no read-back.
    assign req_direct_wr = req_we && (req_size == SZ_W) && !req_cross;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)            nxt = RESP;
                    else if (req_direct_wr) nxt = WR;
                    else                    nxt = RD;
                end
            end
            RD:      nxt = cross_q ? RD1 : (we_q ? WR : RESP);
            RD1:     nxt = we_q ? WR : RESP;
            WR:      nxt = cross_q ? WR1 : RESP;
            WR1:     nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cross_q <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            word0_q <= '0;
            word1_q <= '0;
            adr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        err_q   <= req_err;
                        cross_q <= req_cross;
                        f3_q    <= req_funct3;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        if (!req_err) adr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                    end
                end
                RD: begin
                    word0_q <= mem_rd;
                    if (cross_q) adr_q <= adr_q + ADDR_W'(4);
                end
                RD1: begin
                    word1_q <= mem_rd;
                    if (we_q) adr_q <= adr_q - ADDR_W'(4);
                end
                WR:      if (cross_q) adr_q <= adr_q + ADDR_W'(4);
                default: ;
            endcase
        end
    end

    lsu_lane_align u_align (
        .window    ({word1_q, word0_q}),
        .offset    (off_q),
        .funct3    (f3_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .store_lo  (store_lo),
        .store_hi  (store_hi)
    );

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !we_q && !err_q) ? load_data : '0;
    // Gated by rst so an aborted write never reaches memory on the reset edge.
    assign mem_we     = ((state == WR) || (state == WR1)) && !rst;
    assign mem_wd     = (state == WR) ? store_lo : ((state == WR1) ? store_hi : '0);
    assign mem_adr    = adr_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random requests
// checked against a byte-array reference memory.
module tb_load_store_unit;
    import lsu_pkg::*;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_adr, mem_wd, mem_rd;
    logic        mem_we;

    logic [31:0] mem [256];
    logic [7:0]  rb  [1024];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_val;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_adr    (mem_adr),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    assign mem_rd = mem[mem_adr[9:2]];

    always @(posedge clk) begin
        if (pl_en)       mem[pl_idx] <= pl_val;
        else if (mem_we) mem[mem_adr[9:2]] <= mem_wd;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = addr[9:2]; pl_val = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
        for (int k = 0; k < 4; k++) rb[{addr[9:2], 2'b00} + k] = val[8*k +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {rb[4*idx+3], rb[4*idx+2], rb[4*idx+1], rb[4*idx]};
    endfunction

    // Reference behaviour from byte-level semantics; updates rb for stores.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] e_rd, output logic e_er,
                         output int e_lat, output int e_words, output int e_first);
        int size, off, a, words;
        bit sup;
        logic [31:0] v;
        size = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        sup  = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
        a    = int'(addr[9:0]);
        off  = a % 4;
        e_rd = 32'h0; e_words = 0; e_first = 0;
        e_er = !sup || (((a % size) != 0) && !SPLIT);
        words = (off + size > 4) ? 2 : 1;
        if (e_er) begin
            e_lat = 1;
        end else if (!we) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v |= 32'(rb[(a + i) % 1024]) << (8 * i);
            if (f3 == 3'd0)      e_rd = {{24{v[7]}}, v[7:0]};
            else if (f3 == 3'd1) e_rd = {{16{v[15]}}, v[15:0]};
            else                 e_rd = v;
            e_lat = words + 1;
        end else begin
            for (int i = 0; i < size; i++) rb[(a + i) % 1024] = wd[8*i +: 8];
            e_words = words;
            if (size == 4 && words == 1) begin e_lat = 2; e_first = 1; end
            else begin e_lat = 2 * words + 1; e_first = words + 1; end
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er);
        logic [31:0] e_rd;
        logic        e_er;
        int e_lat, e_words, e_first, cnt, wes, first_we, widx;
        bit got;
        model(we, f3, addr, wd, e_rd, e_er, e_lat, e_words, e_first);
        @(negedge clk);
        chk("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        cnt = 0; wes = 0; first_we = 0; got = 0; rd = 'x; er = 'x;
        while (!got && cnt < 16) begin
            @(negedge clk);
            cnt++;
            if (mem_we) begin wes++; if (first_we == 0) first_we = cnt; end
            if (resp_valid) begin got = 1; rd = resp_rdata; er = resp_err; end
        end
        chk("resp_latency", 32'(cnt), 32'(e_lat));
        chk("resp_rdata", rd, e_rd);
        chk("resp_err", 32'(er), 32'(e_er));
        chk("mem_we_pulses", 32'(wes), 32'(e_words));
        if (e_words > 0) begin
            chk("first_we_cycle", 32'(first_we), 32'(e_first));
            widx = int'(addr[9:2]);
            chk("mem_word0", mem[widx], ref_word(widx));
            if (e_words == 2) chk("mem_word1", mem[(widx + 1) % 256], ref_word((widx + 1) % 256));
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; pl_en = 1'b0; pl_idx = 8'h0; pl_val = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", resp_err, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_adr", mem_adr, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        for (int i = 0; i < 256; i++) set_word(32'(i * 4), $urandom);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_ready", req_ready, 1'b1);
            chk("idle_resp_valid", resp_valid, 1'b0);
            chk("idle_mem_we", mem_we, 1'b0);
        end

        set_word(32'h10, 32'h8899AABB);
        do_req(1'b0, F3_B,  32'h11, 32'h0, rd, er); chk("lb_0x11", rd, 32'hFFFFFFAA);
        do_req(1'b0, F3_BU, 32'h11, 32'h0, rd, er); chk("lbu_0x11", rd, 32'h000000AA);
        do_req(1'b0, F3_H,  32'h12, 32'h0, rd, er); chk("lh_0x12", rd, 32'hFFFF8899);

        set_word(32'h20, 32'h11223344);
        do_req(1'b1, F3_B, 32'h22, 32'hDEADBEEF, rd, er);
        chk("sb_mem", mem[8], 32'h11EF3344);
        chk("sb_err", er, 1'b0);

        do_req(1'b1, F3_W, 32'h30, 32'hCAFEF00D, rd, er);
        chk("sw_mem", mem[12], 32'hCAFEF00D);

        set_word(32'h40, 32'h44332211);
        set_word(32'h44, 32'h88776655);
        do_req(1'b0, F3_W, 32'h41, 32'h0, rd, er);
        chk("lw_0x41_rdata", rd, SPLIT ? 32'h55443322 : 32'h0);
        chk("lw_0x41_err", er, !SPLIT);

        // Reset during the write cycle of an SB must abort without writing.
        set_word(32'h20, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B;
        req_addr = 32'h22; req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_wr", mem_we, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_we_gated", mem_we, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_mem", mem[8], 32'h11223344);
        chk("abort_idle", req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_resp", resp_valid, 1'b0);
            chk("abort_no_we", mem_we, 1'b0);
        end

        for (int i = 0; i < 120; i++) begin
            do_req(1'($urandom), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 1023)),
                   $urandom, rd, er);
        end

        for (int i = 0; i < 256; i++) chk("final_mem", mem[i], ref_word(i));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
